uart_tx_frame: RTL



---
 rtl/uart_tx_frame.sv | 101 ++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit framer: start, LSB-first data, optional parity, one stop bit
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   shreg_q;
    logic [CW-1:0]           cnt_q;
    logic                    par_en_q;
    logic                    par_q;
    logic                    tx_q;
    logic                    busy_q;

    // Outputs are registered alongside the state so each edge already presents the bit of the state being entered.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (Data_Valid) begin
                        state_q  <= S_START;
                        shreg_q  <= P_DATA;
                        par_en_q <= PAR_EN;
                        par_q    <= (^P_DATA) ^ PAR_TYP;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                S_START: begin
                    state_q <= S_DATA;
                    tx_q    <= shreg_q[0];
                    shreg_q <= shreg_q >> 1;
                    cnt_q   <= '0;
                end
                S_DATA: begin
                    if (cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_q <= S_PARITY;
                            tx_q    <= par_q;
                        end else begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        tx_q    <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    state_q <= S_STOP;
                    tx_q    <= 1'b1;
                end
                S_STOP: begin
                    // Never accepts here, so every frame is followed by at least one idle bit.
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule
